// File: rtl/kim1_led_capture.sv
// kim1_led_capture: de-multiplexes the KIM-1 seven-segment scan into a
// flicker-free frame buffer with dwell filtering and persistence decay.
//
// Ports:
//   phi2         RRIOT bus clock
//   rst          asynchronous reset, active-high
//   pao, ddra    port A output / direction registers (segments on PA6..PA0)
//   pbo, ddrb    port B output / direction registers (digit code on PB4..PB1)
//   digit_seg    captured segments, digit i in [7i+6:7i], bit 0 = segment a
//   digit_lit    1 = digit i holds a live capture
//   sel_digit    registered decoded digit index, 7 = no valid select
//   frame_strobe one-cycle pulse once every digit has been captured
module kim1_led_capture #(
  parameter int NUM_DIGITS = 6,
  parameter int SEL_BASE   = 4,
  parameter int MIN_DWELL  = 8,
  parameter int PERSIST    = 20000
) (
  input  logic                    phi2,
  input  logic                    rst,
  input  logic [7:0]              pao,
  input  logic [7:0]              ddra,
  input  logic [7:0]              pbo,
  input  logic [7:0]              ddrb,
  output logic [7*NUM_DIGITS-1:0] digit_seg,
  output logic [NUM_DIGITS-1:0]   digit_lit,
  output logic [2:0]              sel_digit,
  output logic                    frame_strobe
);

  localparam int CW = $clog2(MIN_DWELL + 1);
  localparam int PW = $clog2(PERSIST + 1);

  localparam logic [4:0] SEL_LO =
    5'(SEL_BASE);
  localparam logic [4:0] SEL_HI =
    5'(SEL_BASE + NUM_DIGITS);

  localparam logic [CW-1:0] DWELL_END =
    CW'(MIN_DWELL);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  localparam logic [PW-1:0] P_LOAD = PW'(PERSIST);
  localparam logic [PW-1:0] P_ONE  = PW'(1);

  localparam logic [NUM_DIGITS-1:0] ALL_SEEN = '1;

  typedef enum logic [1:0] {
    IDLE,
    DWELL,
    HELD
  } state_t;

  // ------------------------------------------------------------
  // Effective select and segments
  // ------------------------------------------------------------
  logic [4:0] code;
  logic       sel_ok;
  logic [2:0] idx;
  logic [6:0] seg;
  logic       unused_bits;

  assign code = {1'b0, pbo[4:1]};

  // All four select lines must be driven as outputs, otherwise the
  // code on PB4..PB1 is not what the software intends to show.
  assign sel_ok = (ddrb[4:1] == 4'hF) &&
                  (code >= SEL_LO) &&
                  (code < SEL_HI);

  assign idx = 3'(code - SEL_LO);

  // Lines configured as inputs cannot sink segment current.
  assign seg = pao[6:0] & ddra[6:0];

  assign unused_bits = ^{pao[7], ddra[7],
                         pbo[7:5], pbo[0],
                         ddrb[7:5], ddrb[0]};

  // ------------------------------------------------------------
  // Capture FSM
  // ------------------------------------------------------------
  state_t        state;
  logic [2:0]    cand_idx;
  logic [6:0]    cand_seg;
  logic [CW-1:0] cnt;

  logic [CW-1:0] cnt_inc;
  logic          same;
  logic          tracking;
  logic          do_cap;
  logic          do_ref;

  always_comb begin
    cnt_inc  = cnt + CNT_ONE;
    same     = (idx == cand_idx) &&
               (seg == cand_seg);
    tracking = sel_ok && same &&
               (state != IDLE);
    do_cap   = tracking &&
               (state == DWELL) &&
               (cnt_inc == DWELL_END);
    do_ref   = tracking &&
               (state == HELD);
  end

  always_ff @(posedge phi2 or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cand_idx  <= '0;
      cand_seg  <= '0;
      cnt       <= '0;
      sel_digit <= 3'd7;
    end else begin
      sel_digit <= sel_ok ? idx : 3'd7;
      if (!sel_ok) begin
        state <= IDLE;
      end else if (state == IDLE || !same) begin
        // New candidate: the dwell starts over.
        state    <= DWELL;
        cand_idx <= idx;
        cand_seg <= seg;
        cnt      <= CNT_ONE;
      end else begin
        case (state)
          DWELL: begin
            cnt <= cnt_inc;
            if (cnt_inc == DWELL_END)
              state <= HELD;
          end
          default: begin
            state <= state;
          end
        endcase
      end
    end
  end

  // ------------------------------------------------------------
  // Per-digit frame buffer, persistence and frame tracking
  // ------------------------------------------------------------
  logic [NUM_DIGITS-1:0] cap_mask;
  logic [NUM_DIGITS-1:0] touch_mask;
  logic [NUM_DIGITS-1:0] seen;
  logic [PW-1:0]         persist [NUM_DIGITS];
  logic                  seen_all;

  always_comb begin
    cap_mask   = '0;
    touch_mask = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (cand_idx == 3'(i)) begin
        cap_mask[i]   = do_cap;
        touch_mask[i] = do_cap | do_ref;
      end
    end
  end

  assign seen_all = (seen == ALL_SEEN);

  always_ff @(posedge phi2 or posedge rst) begin
    if (rst) begin
      digit_seg    <= '0;
      digit_lit    <= '0;
      frame_strobe <= 1'b0;
      seen         <= '0;
      for (int i = 0; i < NUM_DIGITS; i++)
        persist[i] <= '0;
    end else begin
      frame_strobe <= seen_all;
      // A capture in the clearing cycle belongs to the new round.
      seen <= (seen_all ? '0 : seen) | cap_mask;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (touch_mask[i]) begin
          // Refresh beats expiry on the same cycle.
          persist[i] <= P_LOAD;
          if (cap_mask[i]) begin
            digit_seg[7*i +: 7] <= cand_seg;
            digit_lit[i]        <= 1'b1;
          end
        end else if (persist[i] != '0) begin
          persist[i] <= persist[i] - P_ONE;
          if (persist[i] == P_ONE) begin
            digit_seg[7*i +: 7] <= 7'h00;
            digit_lit[i]        <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_kim1_led_capture.sv
// tb_kim1_led_capture: vector table for select decode/masking plus
// hand sequences for dwell, reset, frame strobe and persistence.
module tb_kim1_led_capture;

  localparam int ND = 6;
  localparam int MD = 8;
  localparam int PS = 50;

  logic          phi2;
  logic          rst;
  logic [7:0]    pao, ddra, pbo, ddrb;
  logic [41:0]   digit_seg;
  logic [ND-1:0] digit_lit;
  logic [2:0]    sel_digit;
  logic          frame_strobe;

  int errs   = 0;
  int checks = 0;
  int strobes = 0;

  kim1_led_capture #(
    .NUM_DIGITS(ND),
    .SEL_BASE(4),
    .MIN_DWELL(MD),
    .PERSIST(PS)
  ) dut (
    .phi2(phi2),
    .rst(rst),
    .pao(pao),
    .ddra(ddra),
    .pbo(pbo),
    .ddrb(ddrb),
    .digit_seg(digit_seg),
    .digit_lit(digit_lit),
    .sel_digit(sel_digit),
    .frame_strobe(frame_strobe)
  );

  initial phi2 = 1'b0;
  always #5 phi2 = ~phi2;

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0]  ddrb;
    logic [3:0]  code;
    logic [7:0]  ddra;
    logic [7:0]  pao;
    logic [2:0]  sel;
    logic [5:0]  lit;
    logic [41:0] seg;
  } vec_t;

  typedef struct {
    int         d;
    logic [6:0] s;
  } exp_t;

  vec_t tbl [11];
  int   sel_q [$];
  exp_t cap_q [$];

  task automatic chk(input string nm,
                     input longint got,
                     input longint exp);
    checks++;
    if (got != exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h",
               nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge phi2);
    #1;
    strobes += int'(frame_strobe);
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic drive(input logic [7:0] b_dir,
                       input logic [3:0] c,
                       input logic [7:0] a_dir,
                       input logic [7:0] a);
    ddrb = b_dir;
    pbo  = {3'b000, c, 1'b0};
    ddra = a_dir;
    pao  = a;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(8'h00, 4'h0, 8'h00, 8'h00);
    ticks(2);
    rst = 1'b0;
  endtask

  initial begin
    tbl[0]  = '{8'h1E, 4'd3,  8'h7F, 8'h06,
                3'd7, 6'h00, 42'h0};
    tbl[1]  = '{8'h1E, 4'd10, 8'h7F, 8'h06,
                3'd7, 6'h00, 42'h0};
    tbl[2]  = '{8'h0E, 4'd5,  8'h7F, 8'h06,
                3'd7, 6'h00, 42'h0};
    tbl[3]  = '{8'h1C, 4'd4,  8'h7F, 8'h06,
                3'd7, 6'h00, 42'h0};
    tbl[4]  = '{8'h1E, 4'd15, 8'h7F, 8'h06,
                3'd7, 6'h00, 42'h0};
    tbl[5]  = '{8'h1E, 4'd0,  8'h7F, 8'h06,
                3'd7, 6'h00, 42'h0};
    tbl[6]  = '{8'h1E, 4'd9,  8'h7F, 8'h06,
                3'd5, 6'h20, 42'h06 << 35};
    tbl[7]  = '{8'h1E, 4'd4,  8'h7F, 8'h86,
                3'd0, 6'h01, 42'h06};
    tbl[8]  = '{8'h1E, 4'd6,  8'h00, 8'h7F,
                3'd2, 6'h04, 42'h0};
    tbl[9]  = '{8'h1E, 4'd7,  8'h0F, 8'h7F,
                3'd3, 6'h08, 42'h0F << 21};
    tbl[10] = '{8'hFF, 4'd8,  8'hFF, 8'hFF,
                3'd4, 6'h10, 42'h7F << 28};

    rst = 1'b1;
    drive(8'h00, 4'h0, 8'h00, 8'h00);
    ticks(2);
    chk("rst_seg", digit_seg, 0);
    chk("rst_lit", digit_lit, 0);
    chk("rst_sel", sel_digit, 7);
    chk("rst_strobe", frame_strobe, 0);
    rst = 1'b0;

    // Decode / masking vectors, each from a clean reset.
    foreach (tbl[v]) begin
      do_reset();
      drive(tbl[v].ddrb, tbl[v].code,
            tbl[v].ddra, tbl[v].pao);
      sel_q.push_back(int'(tbl[v].sel));
      tick();
      chk($sformatf("vec%0d_sel", v),
          sel_digit, sel_q.pop_front());
      ticks(MD);
      chk($sformatf("vec%0d_lit", v),
          digit_lit, tbl[v].lit);
      chk($sformatf("vec%0d_seg", v),
          digit_seg, tbl[v].seg);
    end

    // Basic capture timing on digit 0.
    do_reset();
    drive(8'h1E, 4'd4, 8'h7F, 8'h06);
    tick();
    chk("basic_sel", sel_digit, 0);
    ticks(6);
    chk("basic_early", digit_lit[0], 0);
    tick();
    chk("basic_lit", digit_lit[0], 1);
    chk("basic_seg", digit_seg[6:0], 7'h06);

    // Pattern change at cycle 5 defers capture.
    drive(8'h1E, 4'd5, 8'h7F, 8'h06);
    ticks(4);
    pao = 8'h5B;
    ticks(7);
    chk("defer_early", digit_lit[1], 0);
    tick();
    chk("defer_lit", digit_lit[1], 1);
    chk("defer_seg", digit_seg[13:7], 7'h5B);

    // Reset in mid-dwell: no carried-over capture.
    drive(8'h1E, 4'd6, 8'h7F, 8'h4F);
    ticks(4);
    rst = 1'b1;
    #1;
    chk("midrst_lit", digit_lit, 0);
    chk("midrst_seg", digit_seg, 0);
    chk("midrst_sel", sel_digit, 7);
    chk("midrst_strobe", frame_strobe, 0);
    tick();
    rst = 1'b0;
    ticks(7);
    chk("midrst_nocap", digit_lit, 0);
    tick();
    chk("midrst_recap", digit_lit[2], 1);
    chk("midrst_seg2", digit_seg[20:14], 7'h4F);

    // Direction bit dropping restarts the dwell.
    do_reset();
    drive(8'h1E, 4'd7, 8'h0F, 8'h7F);
    ticks(4);
    ddra = 8'h0E;
    ticks(7);
    chk("mask_early", digit_lit[3], 0);
    tick();
    chk("mask_lit", digit_lit[3], 1);
    chk("mask_seg", digit_seg[27:21], 7'h0E);

    // Full frame scans with capture scoreboard.
    do_reset();
    strobes = 0;
    for (int r = 0; r < 2; r++) begin
      for (int d = 0; d < ND; d++) begin
        logic [6:0] pat;
        exp_t e;
        case (d)
          0: pat = 7'h3F;
          1: pat = 7'h06;
          2: pat = 7'h5B;
          3: pat = 7'h4F;
          4: pat = 7'h66;
          default: pat = 7'h6D;
        endcase
        drive(8'h1E, 4'(4 + d), 8'h7F, {1'b0, pat});
        cap_q.push_back('{d, pat});
        ticks(7);
        chk($sformatf("frm%0d_d%0d_early", r, d),
            digit_lit[d], 0);
        tick();
        e = cap_q.pop_front();
        chk($sformatf("frm%0d_d%0d_lit", r, d),
            digit_lit[e.d], 1);
        chk($sformatf("frm%0d_d%0d_seg", r, d),
            digit_seg[7*e.d +: 7], e.s);
        if (d == ND - 1) begin
          chk($sformatf("frm%0d_stb_pre", r),
              frame_strobe, 0);
          tick();
          chk($sformatf("frm%0d_stb", r),
              frame_strobe, 1);
          tick();
          chk($sformatf("frm%0d_stb_post", r),
              frame_strobe, 0);
          ticks(10);
        end else begin
          ticks(12);
        end
      end
      chk($sformatf("frm%0d_count", r),
          strobes, r + 1);
    end

    // Persistence decay after deselect.
    do_reset();
    drive(8'h1E, 4'd6, 8'h7F, 8'h5B);
    ticks(8);
    chk("pers_cap", digit_lit[2], 1);
    ddrb = 8'h00;
    ticks(PS - 1);
    chk("pers_hold_lit", digit_lit[2], 1);
    chk("pers_hold_seg", digit_seg[20:14], 7'h5B);
    tick();
    chk("pers_exp_lit", digit_lit[2], 0);
    chk("pers_exp_seg", digit_seg[20:14], 0);

    // Held select keeps refreshing.
    do_reset();
    begin
      int drops;
      drops = 0;
      drive(8'h1E, 4'd6, 8'h7F, 8'h5B);
      ticks(8);
      for (int k = 0; k < 192; k++) begin
        tick();
        if (!digit_lit[2]) drops++;
      end
      chk("held_drops", drops, 0);
      chk("held_lit", digit_lit[2], 1);
    end

    $display("Result: errors=%0d of %0d checks",
             errs, checks);
    $finish;
  end

endmodule
